pwm_capture16b: RTL and testbench
=================================

# pwm_capture16b

Measures an incoming PWM waveform and reports it as the register pair that a 16-bit PWM generator would need to reproduce it: `cap_arr` (period − 1) and `cap_cvr` (high time − 1). It is the receive-side counterpart of the servo/power PWM generator. Typical uses are reading RC-receiver servo commands and loopback-checking generated PWM. A `cap_valid` pulse marks each completed period, and a watchdog flags a dead or stuck input.

## Interface
Parameters:
- `WIDTH`, 16: counter and result width.
- `FILT_LEN`, 4: number of consecutive equal synchronized samples required to accept a level change (used only with the filter compiled in, range 2..15).

Ports:
- `clk`  in  1  single system clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `pwm_in`  in  1  asynchronous PWM input.
- `cap_arr`  out  WIDTH  last measured period − 1, in clk cycles.
- `cap_cvr`  out  WIDTH  last measured high time − 1, in clk cycles.
- `cap_valid`  out  1  one-cycle pulse; `cap_arr`/`cap_cvr` updated this cycle.
- `timeout`  out  1  no edge for 2^WIDTH−1 cycles; sticky until next `cap_valid`.
- `level`  out  1  current filtered/synchronized input level.

## Operation
- Input path: 2-flop synchronizer, then optional glitch filter (see Configuration), then edge detector on `level`. This produces `rise` and `fall` single-cycle strobes.
- Counter `cnt` (WIDTH bits):
  - Cleared to 0 on the `rise` cycle.
  - Otherwise increments each cycle.
  - Saturates at all-ones and never wraps.
- FSM states: IDLE, HIGH, LOW.
  - IDLE: `fall` is ignored. On `rise` go to HIGH and clear `cnt`. No result is reported, because no complete period has been seen yet.
  - HIGH: on `fall` store `hi_len = cnt` and go to LOW. If `cnt` reaches all-ones, assert `timeout` and go to IDLE.
  - LOW: on `rise` load `cap_arr = cnt − 1` and `cap_cvr = hi_len − 1`, pulse `cap_valid`, clear `timeout`, clear `cnt`, and go to HIGH. If `cnt` reaches all-ones, assert `timeout` and go to IDLE.
- `cnt` is the number of cycles since `rise`. A high time of H cycles and a period of P cycles therefore give `cap_cvr = H − 1` and `cap_arr = P − 1`.
- Outputs hold their last values on timeout. Only `timeout` changes.
- Stuck-high input (100 % duty) or stuck-low input (0 % duty, or input lost) both end in `timeout = 1` with `level` showing the stuck value.
- `rst` mid-operation: the next cycle returns to IDLE, with `cnt = 0` and all outputs at their reset values. The synchronizer and filter are also cleared to 0.

## Timing
- Reset values: `cap_arr = 0`, `cap_cvr = 0`, `cap_valid = 0`, `timeout = 0`, `level = 0`, state IDLE.
- Latency without the filter, from a `pwm_in` transition to `level`: 2 clk. The `rise`/`fall` strobes follow in the same cycle `level` changes, computed against the registered previous `level`.
- `cap_valid` is registered: it asserts 1 clk after the `rise` strobe, which is 3 clk after the `pwm_in` rising edge.
- Constant latency means measured P and H are exact for ideal input. Jitter is ±1 clk from input asynchrony.
- `timeout` asserts on the cycle after `cnt` reaches 2^WIDTH − 1.
- Minimum measurable high or low phase: 1 clk without the filter, FILT_LEN clk with it.

## Configuration
- `PWM_CAP_FILTER_EN` defined: a glitch filter sits after the synchronizer. `level` changes only after FILT_LEN consecutive equal samples differing from the current `level`. This adds FILT_LEN clk of latency to both edges equally, so H and P are unaffected. Pulses shorter than FILT_LEN clk are rejected.
- Not defined: `level` is the synchronizer output directly, and FILT_LEN is ignored.

## Structure
- Shared package `pwm_pkg`:
  - `PWM_WIDTH = 16` (shared with the generator).
  - Capture FSM state enum (IDLE/HIGH/LOW).
  - All-ones saturation constant.
- One sub-module, `pwm_in_filter`, containing the synchronizer, the optional filter and edge detection. It outputs `level`, `rise` and `fall`. The top level holds the FSM, counter and result registers.

## Test plan
- Loopback with the generator, arr=99, cvr=24, filter off: every `cap_valid` after the first full period shows `cap_arr = 99` and `cap_cvr = 24`. The first rising edge after reset produces no `cap_valid`.
- Direct stimulus, high for 10 clk then low for 30 clk, repeated: `cap_cvr = 9` and `cap_arr = 39`, with `cap_valid` 3 clk after each rising edge.
- Input held high for 70000 clk: `timeout = 1` and `level = 1`. The previous `cap_arr`/`cap_cvr` are retained. After a new 10/30 waveform, `timeout` clears on the second `cap_valid`-producing rise.
- `rst` asserted for 1 clk while in LOW: the next cycle shows all outputs at 0 and state IDLE. The next rising edge produces no `cap_valid`.
- `PWM_CAP_FILTER_EN`, FILT_LEN=4, a 2-clk high glitch inside a low phase: `level` stays 0 and the results are unchanged. A 20/50 waveform still yields `cap_cvr = 19` and `cap_arr = 49`.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared PWM definitions: counter width, capture FSM states and saturation constant.
package pwm_pkg;

  localparam int unsigned PWM_WIDTH = 16;

  // All-ones value at which the capture counter saturates.
  localparam logic [PWM_WIDTH-1:0] CntMax = '1;

  typedef enum logic [1:0] {
    StIdle,
    StHigh,
    StLow
  } cap_state_e;

endpackage

// File: rtl/pwm_in_filter.sv
// PWM input conditioning: 2-flop synchronizer, optional glitch filter
// (PWM_CAP_FILTER_EN), and rise/fall strobes on the resulting level.
module pwm_in_filter #(
  parameter int unsigned FILT_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic pwm_in,
  output logic level,
  output logic rise,
  output logic fall
);

  if (FILT_LEN < 2 || FILT_LEN > 15) begin : g_bad_filt_len
    $error("FILT_LEN must be in 2..15");
  end

  logic r_sync1;
  logic r_sync2;
  logic r_level_prev;
  logic w_level;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1      <= 1'b0;
      r_sync2      <= 1'b0;
      r_level_prev <= 1'b0;
    end else begin
      r_sync1      <= pwm_in;
      r_sync2      <= r_sync1;
      r_level_prev <= w_level;
    end
  end

`ifdef PWM_CAP_FILTER_EN
  logic [3:0] r_fcnt;
  logic       r_level;

  // Accept a new level only after FILT_LEN consecutive differing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fcnt  <= 4'd0;
      r_level <= 1'b0;
    end else if (r_sync2 != r_level) begin
      if (r_fcnt == 4'(FILT_LEN - 1)) begin
        r_fcnt  <= 4'd0;
        r_level <= r_sync2;
      end else begin
        r_fcnt <= r_fcnt + 4'd1;
      end
    end else begin
      r_fcnt <= 4'd0;
    end
  end

  assign w_level = r_level;
`else
  assign w_level = r_sync2;
`endif

  assign level = w_level;
  assign rise  = w_level & ~r_level_prev;
  assign fall  = ~w_level & r_level_prev;

endmodule

// File: rtl/pwm_capture16b.sv
// PWM capture: measures period and high time as generator-style ARR/CVR values,
// with a stuck-input watchdog. Glitch filter enabled by PWM_CAP_FILTER_EN.
module pwm_capture16b
  import pwm_pkg::*;
#(
  parameter int unsigned WIDTH    = PWM_WIDTH,
  parameter int unsigned FILT_LEN = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_in,
  output logic [WIDTH-1:0] cap_arr,
  output logic [WIDTH-1:0] cap_cvr,
  output logic             cap_valid,
  output logic             timeout,
  output logic             level
);

  localparam logic [WIDTH-1:0] CntSat = '1;

  logic w_rise;
  logic w_fall;

  pwm_in_filter #(
    .FILT_LEN (FILT_LEN)
  ) u_in_filter (
    .clk    (clk),
    .rst    (rst),
    .pwm_in (pwm_in),
    .level  (level),
    .rise   (w_rise),
    .fall   (w_fall)
  );

  cap_state_e       r_state, w_state_next;
  logic [WIDTH-1:0] r_cnt, w_cnt_next;
  logic [WIDTH-1:0] r_hi_len, w_hi_len_next;
  logic [WIDTH-1:0] r_arr, w_arr_next;
  logic [WIDTH-1:0] r_cvr, w_cvr_next;
  logic             r_valid, w_valid_next;
  logic             r_timeout, w_timeout_next;

  always_comb begin
    w_state_next   = r_state;
    w_hi_len_next  = r_hi_len;
    w_arr_next     = r_arr;
    w_cvr_next     = r_cvr;
    w_valid_next   = 1'b0;
    w_timeout_next = r_timeout;

    // The rise cycle is cycle 0 of the new period, so the register holds 1 next.
    if (w_rise) begin
      w_cnt_next = WIDTH'(1);
    end else if (r_cnt == CntSat) begin
      w_cnt_next = r_cnt;
    end else begin
      w_cnt_next = r_cnt + WIDTH'(1);
    end

    case (r_state)
      StIdle: begin
        if (w_rise) begin
          w_state_next = StHigh;
        end
      end
      StHigh: begin
        if (w_fall) begin
          w_hi_len_next = r_cnt;
          w_state_next  = StLow;
        end else if (r_cnt == CntSat) begin
          w_timeout_next = 1'b1;
          w_state_next   = StIdle;
        end
      end
      StLow: begin
        if (w_rise) begin
          w_arr_next     = r_cnt - WIDTH'(1);
          w_cvr_next     = r_hi_len - WIDTH'(1);
          w_valid_next   = 1'b1;
          w_timeout_next = 1'b0;
          w_state_next   = StHigh;
        end else if (r_cnt == CntSat) begin
          w_timeout_next = 1'b1;
          w_state_next   = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_hi_len  <= '0;
      r_arr     <= '0;
      r_cvr     <= '0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_hi_len  <= w_hi_len_next;
      r_arr     <= w_arr_next;
      r_cvr     <= w_cvr_next;
      r_valid   <= w_valid_next;
      r_timeout <= w_timeout_next;
    end
  end

  assign cap_arr   = r_arr;
  assign cap_cvr   = r_cvr;
  assign cap_valid = r_valid;
  assign timeout   = r_timeout;

endmodule

// File: tb/tb_pwm_capture16b.sv
// Directed self-checking bench for pwm_capture16b; the glitch scenario runs
// only when PWM_CAP_FILTER_EN is defined.
module tb_pwm_capture16b;

`ifdef PWM_CAP_FILTER_EN
  localparam int Lat = 2 + 4;
`else
  localparam int Lat = 2;
`endif

  logic        clk;
  logic        rst;
  logic        pwm_in;
  logic [15:0] cap_arr;
  logic [15:0] cap_cvr;
  logic        cap_valid;
  logic        timeout;
  logic        level;

  int checks = 0;
  int errors = 0;

  pwm_capture16b #(
    .WIDTH    (16),
    .FILT_LEN (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pwm_in    (pwm_in),
    .cap_arr   (cap_arr),
    .cap_cvr   (cap_cvr),
    .cap_valid (cap_valid),
    .timeout   (timeout),
    .level     (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One period: hi cycles high then lo cycles low. cap_valid is expected Lat
  // samples after the rising drive, carrying the previous period's values.
  task automatic run_period(input int hi, input int lo, input bit exp_valid,
                            input logic [15:0] exp_arr, input logic [15:0] exp_cvr,
                            input string name);
    for (int i = 0; i < hi + lo; i++) begin
      pwm_in = (i < hi);
      step();
      if (i == Lat) begin
        checks++;
        if (cap_valid !== exp_valid) begin
          errors++;
          $display("FAIL %s valid: got %b expected %b", name, cap_valid, exp_valid);
        end
        if (exp_valid) begin
          checks++;
          if (cap_arr !== exp_arr || cap_cvr !== exp_cvr) begin
            errors++;
            $display("FAIL %s result: got arr=%0d cvr=%0d expected arr=%0d cvr=%0d",
                     name, cap_arr, cap_cvr, exp_arr, exp_cvr);
          end
        end
      end else if (i == Lat - 1 || i == Lat + 1) begin
        checks++;
        if (cap_valid !== 1'b0) begin
          errors++;
          $display("FAIL %s stray valid at %0d: got %b expected 0", name, i, cap_valid);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    pwm_in = 1'b0;
    repeat (3) step();
    checks++;
    if (cap_arr !== 16'd0 || cap_cvr !== 16'd0 || cap_valid !== 1'b0 ||
        timeout !== 1'b0 || level !== 1'b0) begin
      errors++;
      $display("FAIL reset: got arr=%0d cvr=%0d valid=%b timeout=%b level=%b expected all 0",
               cap_arr, cap_cvr, cap_valid, timeout, level);
    end
    rst = 1'b0;
    repeat (5) step();
  endtask

  task automatic test_basic();
    run_period(10, 30, 1'b0, 16'd0, 16'd0, "first_rise");
    run_period(10, 30, 1'b1, 16'd39, 16'd9, "p10_30_a");
    run_period(10, 30, 1'b1, 16'd39, 16'd9, "p10_30_b");
    run_period(5, 7, 1'b1, 16'd39, 16'd9, "p5_7_a");
    run_period(5, 7, 1'b1, 16'd11, 16'd4, "p5_7_b");
  endtask

  task automatic test_min_phase();
`ifndef PWM_CAP_FILTER_EN
    run_period(1, 3, 1'b1, 16'd11, 16'd4, "p1_3_a");
    run_period(1, 3, 1'b1, 16'd3, 16'd0, "p1_3_b");
    run_period(1, 3, 1'b1, 16'd3, 16'd0, "p1_3_c");
    run_period(25, 75, 1'b1, 16'd3, 16'd0, "loop_a");
`else
    run_period(25, 75, 1'b1, 16'd11, 16'd4, "loop_a");
`endif
  endtask

  task automatic test_loopback();
    run_period(25, 75, 1'b1, 16'd99, 16'd24, "loop_b");
    run_period(25, 75, 1'b1, 16'd99, 16'd24, "loop_c");
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 70000; i++) begin
      pwm_in = 1'b1;
      step();
      if (i == 65000) begin
        checks++;
        if (timeout !== 1'b0) begin
          errors++;
          $display("FAIL timeout_early: got %b expected 0", timeout);
        end
      end
    end
    checks++;
    if (timeout !== 1'b1 || level !== 1'b1) begin
      errors++;
      $display("FAIL timeout_stuck_high: got timeout=%b level=%b expected 1 1", timeout, level);
    end
    checks++;
    if (cap_arr !== 16'd99 || cap_cvr !== 16'd24) begin
      errors++;
      $display("FAIL timeout_hold: got arr=%0d cvr=%0d expected 99 24", cap_arr, cap_cvr);
    end
    pwm_in = 1'b0;
    repeat (30) step();
    run_period(10, 30, 1'b0, 16'd0, 16'd0, "recover_first");
    checks++;
    if (timeout !== 1'b1) begin
      errors++;
      $display("FAIL timeout_sticky: got %b expected 1", timeout);
    end
    run_period(10, 30, 1'b1, 16'd39, 16'd9, "recover_second");
    checks++;
    if (timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_clear: got %b expected 0", timeout);
    end
  endtask

  task automatic test_reset_mid_low();
    pwm_in = 1'b1;
    repeat (10) step();
    pwm_in = 1'b0;
    repeat (15) step();
    rst = 1'b1;
    step();
    checks++;
    if (cap_arr !== 16'd0 || cap_cvr !== 16'd0 || cap_valid !== 1'b0 ||
        timeout !== 1'b0 || level !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_low: got arr=%0d cvr=%0d valid=%b timeout=%b level=%b expected 0",
               cap_arr, cap_cvr, cap_valid, timeout, level);
    end
    rst = 1'b0;
    repeat (20) step();
    run_period(10, 30, 1'b0, 16'd0, 16'd0, "post_reset_first");
    run_period(10, 30, 1'b1, 16'd39, 16'd9, "post_reset_second");
  endtask

  task automatic test_glitch();
`ifdef PWM_CAP_FILTER_EN
    run_period(20, 30, 1'b1, 16'd39, 16'd9, "f20_50_a");
    pwm_in = 1'b1;
    repeat (20) step();
    for (int i = 0; i < 30; i++) begin
      pwm_in = (i == 10 || i == 11);
      step();
      if (i >= 10 && i < 20) begin
        checks++;
        if (level !== 1'b0) begin
          errors++;
          $display("FAIL glitch_level at %0d: got %b expected 0", i, level);
        end
      end
    end
    run_period(20, 30, 1'b1, 16'd49, 16'd19, "f20_50_b");
    run_period(20, 30, 1'b1, 16'd49, 16'd19, "f20_50_c");
`endif
  endtask

  initial begin
    rst    = 1'b1;
    pwm_in = 1'b0;
    test_reset();
    test_basic();
    test_min_phase();
    test_loopback();
    test_timeout();
    test_reset_mid_low();
    test_glitch();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
